// File: rtl/phv_field_insert_pkg.sv
// Shared definitions for the PHV field insert block: FSM states, default widths,
// and the slot-count derivation used by the interface and the RTL.
package phv_field_insert_pkg;

   localparam int PHV_WIDTH_DEF    = 1024;
   localparam int INSERT_WIDTH_DEF = 8;
   localparam int CNT_WIDTH_DEF    = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EDIT = 2'd1,
      OUT  = 2'd2
   } phv_ins_state_e;

   function automatic int slot_num(input int phv_w, input int ins_w);
      return phv_w / ins_w;
   endfunction

endpackage

// File: rtl/phv_field_insert_if.sv
// Handshake bundle for phv_field_insert: PHV in, edit commands, edited PHV out,
// plus the per-PHV status outputs.
interface phv_field_insert_if
   import phv_field_insert_pkg::*;
#(
   parameter int PHV_WIDTH    = PHV_WIDTH_DEF,
   parameter int INSERT_WIDTH = INSERT_WIDTH_DEF,
   parameter int CNT_WIDTH    = CNT_WIDTH_DEF
) ();
   localparam int SLOT_NUM     = slot_num(PHV_WIDTH, INSERT_WIDTH);
   localparam int OFFSET_WIDTH = $clog2(SLOT_NUM);

   logic                    i_phv_valid;
   logic [PHV_WIDTH-1:0]    i_phv;
   logic                    i_phv_nocmd;
   logic                    o_phv_ready;
   logic                    i_cmd_valid;
   logic [OFFSET_WIDTH-1:0] i_cmd_offset;
   logic [INSERT_WIDTH-1:0] i_cmd_data;
   logic                    i_cmd_last;
   logic                    o_cmd_ready;
   logic                    o_phv_valid;
   logic [PHV_WIDTH-1:0]    o_phv;
   logic                    i_phv_ready;
   logic [CNT_WIDTH-1:0]    o_cmd_cnt;
   logic                    o_oob;

   modport slave (
      input  i_phv_valid, i_phv, i_phv_nocmd,
      input  i_cmd_valid, i_cmd_offset, i_cmd_data, i_cmd_last,
      input  i_phv_ready,
      output o_phv_ready, o_cmd_ready, o_phv_valid, o_phv, o_cmd_cnt, o_oob
   );

   modport master (
      output i_phv_valid, i_phv, i_phv_nocmd,
      output i_cmd_valid, i_cmd_offset, i_cmd_data, i_cmd_last,
      output i_phv_ready,
      input  o_phv_ready, o_cmd_ready, o_phv_valid, o_phv, o_cmd_cnt, o_oob
   );

endinterface

// File: rtl/phv_slot_write.sv
// Combinational slot replace: returns the PHV with one INSERT_WIDTH slot overwritten,
// or unchanged when disabled or when the offset lies past the last slot.
module phv_slot_write #(
   parameter int PHV_WIDTH    = 1024,
   parameter int INSERT_WIDTH = 8,
   parameter int SLOT_NUM     = PHV_WIDTH / INSERT_WIDTH,
   parameter int OFFSET_WIDTH = $clog2(SLOT_NUM)
) (
   input  logic [PHV_WIDTH-1:0]    phv,
   input  logic [OFFSET_WIDTH-1:0] offset,
   input  logic [INSERT_WIDTH-1:0] data,
   input  logic                    en,
   output logic [PHV_WIDTH-1:0]    phv_out,
   output logic                    oob
);

   always_comb begin
      phv_out = phv;
      oob     = (int'(offset) >= SLOT_NUM);
      // Per-slot compare keeps the part-select constant; offsets past SLOT_NUM match nothing.
      for (int i = 0; i < SLOT_NUM; i++) begin
         if (en && (offset == OFFSET_WIDTH'(i))) begin
            phv_out[i*INSERT_WIDTH +: INSERT_WIDTH] = data;
         end
      end
   end

endmodule

// File: rtl/phv_field_insert.sv
// Loads one PHV, applies (slot, data) overwrite commands in order, then presents
// the edited PHV downstream.
//
// state | meaning
// IDLE  | waiting for a PHV; o_phv_ready=1
// EDIT  | PHV held, accepting commands; o_cmd_ready=1
// OUT   | edited PHV presented; o_phv_valid=1 until i_phv_ready
module phv_field_insert
   import phv_field_insert_pkg::*;
#(
   parameter int PHV_WIDTH    = PHV_WIDTH_DEF,
   parameter int INSERT_WIDTH = INSERT_WIDTH_DEF,
   parameter int SLOT_NUM     = slot_num(PHV_WIDTH, INSERT_WIDTH),
   parameter int OFFSET_WIDTH = $clog2(SLOT_NUM),
   parameter int CNT_WIDTH    = CNT_WIDTH_DEF
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   phv_field_insert_if.slave  bus
);

   phv_ins_state_e          state_q, state_d;
   logic [PHV_WIDTH-1:0]    phv_q;
   logic [PHV_WIDTH-1:0]    phv_wr;
   logic [CNT_WIDTH-1:0]    cnt_q;
   logic                    oob_q;
   logic                    wr_oob;
   logic                    phv_load;
   logic                    cmd_fire;

   assign phv_load = (state_q == IDLE) && bus.i_phv_valid;
   assign cmd_fire = (state_q == EDIT) && bus.i_cmd_valid;

   phv_slot_write #(
      .PHV_WIDTH    (PHV_WIDTH),
      .INSERT_WIDTH (INSERT_WIDTH),
      .SLOT_NUM     (SLOT_NUM),
      .OFFSET_WIDTH (OFFSET_WIDTH)
   ) u_slot_write (
      .phv     (phv_q),
      .offset  (bus.i_cmd_offset),
      .data    (bus.i_cmd_data),
      .en      (cmd_fire),
      .phv_out (phv_wr),
      .oob     (wr_oob)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (bus.i_phv_valid) state_d = bus.i_phv_nocmd ? OUT : EDIT;
         EDIT: if (bus.i_cmd_valid && bus.i_cmd_last) state_d = OUT;
         OUT:  if (bus.i_phv_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         phv_q <= '0;
         cnt_q <= '0;
         oob_q <= 1'b0;
      end else if (phv_load) begin
         phv_q <= bus.i_phv;
         cnt_q <= '0;
         oob_q <= 1'b0;
      end else if (cmd_fire) begin
         phv_q <= phv_wr;
         if (cnt_q != {CNT_WIDTH{1'b1}}) cnt_q <= cnt_q + 1'b1;
         if (wr_oob) oob_q <= 1'b1;
      end
   end

   // Readies and valid come from state alone so reset drops them asynchronously.
   assign bus.o_phv_ready = (state_q == IDLE);
   assign bus.o_cmd_ready = (state_q == EDIT);
   assign bus.o_phv_valid = (state_q == OUT);
   assign bus.o_phv       = phv_q;
   assign bus.o_cmd_cnt   = cnt_q;
   assign bus.o_oob       = oob_q;

endmodule

// File: tb/tb_phv_field_insert.sv
// Self-checking bench for phv_field_insert: a 1024-bit instance with a byte-array
// model, and a 1000-bit instance for the out-of-range offset case.
module tb_phv_field_insert;
   import phv_field_insert_pkg::*;

   localparam int PW  = 1024;
   localparam int PWS = 1000;
   localparam int IW  = 8;
   localparam int CW  = 8;

   logic i_clk   = 1'b0;
   logic i_rst_n = 1'b0;
   always #5 i_clk = ~i_clk;

   phv_field_insert_if #(.PHV_WIDTH(PW),  .INSERT_WIDTH(IW), .CNT_WIDTH(CW)) bus ();
   phv_field_insert_if #(.PHV_WIDTH(PWS), .INSERT_WIDTH(IW), .CNT_WIDTH(CW)) sbus ();

   phv_field_insert #(.PHV_WIDTH(PW), .INSERT_WIDTH(IW), .CNT_WIDTH(CW)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .bus     (bus)
   );

   phv_field_insert #(.PHV_WIDTH(PWS), .INSERT_WIDTH(IW), .CNT_WIDTH(CW)) dut_s (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .bus     (sbus)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: the PHV as an array of bytes plus a saturating command count.
   logic [7:0] mslot [128];
   int         mcnt;

   function automatic logic [PW-1:0] model_phv();
      logic [PW-1:0] r;
      for (int i = 0; i < 128; i++) r[i*8 +: 8] = mslot[i];
      return r;
   endfunction

   function automatic logic [PW-1:0] rand_phv();
      logic [PW-1:0] r;
      for (int i = 0; i < PW/32; i++) r[i*32 +: 32] = $urandom();
      return r;
   endfunction

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic load_main(input logic [PW-1:0] v, input logic nocmd);
      int n = 0;
      while (bus.o_phv_ready !== 1'b1 && n < 20) begin step(); n++; end
      total++;
      if (n >= 20) begin
         bad++;
         $display("FAIL load_wait o_phv_ready=%b required=1", bus.o_phv_ready);
      end
      bus.i_phv       = v;
      bus.i_phv_nocmd = nocmd;
      bus.i_phv_valid = 1'b1;
      step();
      bus.i_phv_valid = 1'b0;
      bus.i_phv_nocmd = 1'b0;
      for (int i = 0; i < 128; i++) mslot[i] = v[i*8 +: 8];
      mcnt = 0;
   endtask

   task automatic send_cmd(input int off, input logic [7:0] data, input logic last);
      int n = 0;
      while (bus.o_cmd_ready !== 1'b1 && n < 20) begin step(); n++; end
      total++;
      if (n >= 20) begin
         bad++;
         $display("FAIL cmd_wait o_cmd_ready=%b required=1", bus.o_cmd_ready);
      end
      bus.i_cmd_offset = 7'(off);
      bus.i_cmd_data   = data;
      bus.i_cmd_last   = last;
      bus.i_cmd_valid  = 1'b1;
      step();
      bus.i_cmd_valid  = 1'b0;
      bus.i_cmd_last   = 1'b0;
      mslot[off] = data;
      if (mcnt < 255) mcnt++;
   endtask

   task automatic accept_out();
      bus.i_phv_ready = 1'b1;
      step();
      bus.i_phv_ready = 1'b0;
   endtask

   task automatic test_reset();
      total++; if (bus.o_phv_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus.o_phv_valid); end
      total++; if (bus.o_cmd_cnt !== 8'd0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", bus.o_cmd_cnt); end
      total++; if (bus.o_oob !== 1'b0) begin bad++; $display("FAIL rst_oob got=%b want=0", bus.o_oob); end
      total++; if (bus.o_phv !== '0) begin bad++; $display("FAIL rst_phv got=%h want=0", bus.o_phv); end
      total++; if (bus.o_phv_ready !== 1'b1) begin bad++; $display("FAIL rst_phv_ready got=%b want=1", bus.o_phv_ready); end
      total++; if (bus.o_cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_cmd_ready got=%b want=0", bus.o_cmd_ready); end
   endtask

   task automatic test_single_write();
      logic [PW-1:0] exp;
      load_main('0, 1'b0);
      total++; if (bus.o_phv_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%b want=0", bus.o_phv_valid); end
      send_cmd(5, 8'hAB, 1'b1);
      exp = '0;
      exp[47:40] = 8'hAB;
      total++; if (bus.o_phv_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", bus.o_phv_valid); end
      total++; if (bus.o_phv !== exp) begin bad++; $display("FAIL single_phv got=%h want=%h", bus.o_phv[63:0], exp[63:0]); end
      total++; if (bus.o_cmd_cnt !== 8'd1) begin bad++; $display("FAIL single_cnt got=%0d want=1", bus.o_cmd_cnt); end
      accept_out();
      total++; if (bus.o_phv_valid !== 1'b0 || bus.o_phv_ready !== 1'b1) begin
         bad++; $display("FAIL single_release valid=%b ready=%b want 0/1", bus.o_phv_valid, bus.o_phv_ready);
      end
   endtask

   task automatic test_overwrite();
      load_main('0, 1'b0);
      send_cmd(3, 8'h11, 1'b0);
      send_cmd(3, 8'h22, 1'b0);
      send_cmd(0, 8'hFF, 1'b1);
      total++; if (bus.o_phv[31:24] !== 8'h22) begin bad++; $display("FAIL ovw_slot3 got=%h want=22", bus.o_phv[31:24]); end
      total++; if (bus.o_phv[7:0] !== 8'hFF) begin bad++; $display("FAIL ovw_slot0 got=%h want=ff", bus.o_phv[7:0]); end
      total++; if (bus.o_phv !== model_phv()) begin bad++; $display("FAIL ovw_phv got=%h want=%h", bus.o_phv[63:0], model_phv() >> 0); end
      total++; if (bus.o_cmd_cnt !== 8'd3) begin bad++; $display("FAIL ovw_cnt got=%0d want=3", bus.o_cmd_cnt); end
      accept_out();
   endtask

   task automatic test_nocmd();
      load_main('1, 1'b1);
      total++; if (bus.o_phv_valid !== 1'b1) begin bad++; $display("FAIL nocmd_valid got=%b want=1", bus.o_phv_valid); end
      total++; if (bus.o_phv !== {PW{1'b1}}) begin bad++; $display("FAIL nocmd_phv got=%h want=all ones", bus.o_phv[63:0]); end
      total++; if (bus.o_cmd_ready !== 1'b0) begin bad++; $display("FAIL nocmd_cmd_ready got=%b want=0", bus.o_cmd_ready); end
      total++; if (bus.o_cmd_cnt !== 8'd0) begin bad++; $display("FAIL nocmd_cnt got=%0d want=0", bus.o_cmd_cnt); end
      accept_out();
      total++; if (bus.o_cmd_ready !== 1'b0) begin bad++; $display("FAIL nocmd_cmd_ready_after got=%b want=0", bus.o_cmd_ready); end
   endtask

   task automatic test_backpressure();
      logic [PW-1:0] v, exp;
      v = rand_phv();
      load_main(v, 1'b0);
      send_cmd(10, 8'hC3, 1'b1);
      exp = model_phv();
      bus.i_cmd_offset = 7'd10;
      bus.i_cmd_data   = 8'h00;
      bus.i_cmd_last   = 1'b1;
      bus.i_cmd_valid  = 1'b1;
      bus.i_phv        = ~v;
      bus.i_phv_valid  = 1'b1;
      for (int c = 0; c < 10; c++) begin
         total++; if (bus.o_phv !== exp) begin bad++; $display("FAIL bp_phv cycle=%0d got=%h want=%h", c, bus.o_phv[95:64], exp[95:64]); end
         total++; if (bus.o_phv_valid !== 1'b1 || bus.o_phv_ready !== 1'b0 || bus.o_cmd_ready !== 1'b0) begin
            bad++; $display("FAIL bp_ctrl cycle=%0d valid=%b phv_ready=%b cmd_ready=%b want 1/0/0",
                            c, bus.o_phv_valid, bus.o_phv_ready, bus.o_cmd_ready);
         end
         step();
      end
      bus.i_cmd_valid = 1'b0;
      bus.i_cmd_last  = 1'b0;
      bus.i_phv_valid = 1'b0;
      total++; if (bus.o_cmd_cnt !== 8'd1) begin bad++; $display("FAIL bp_cnt got=%0d want=1", bus.o_cmd_cnt); end
      accept_out();
   endtask

   task automatic test_boundary();
      logic [PW-1:0]  v;
      logic [PWS-1:0] sv, sexp;
      v = rand_phv();
      load_main(v, 1'b0);
      send_cmd(127, 8'h5A, 1'b1);
      total++; if (bus.o_phv[1023:1016] !== 8'h5A) begin bad++; $display("FAIL top_slot got=%h want=5a", bus.o_phv[1023:1016]); end
      total++; if (bus.o_phv !== model_phv()) begin bad++; $display("FAIL top_phv got=%h want=%h", bus.o_phv[1023:960], v[1023:960]); end
      total++; if (bus.o_oob !== 1'b0) begin bad++; $display("FAIL top_oob got=%b want=0", bus.o_oob); end
      accept_out();

      v  = rand_phv();
      sv = v[PWS-1:0];
      sexp = sv;
      sexp[124*8 +: 8] = 8'h33;
      sbus.i_phv = sv;
      sbus.i_phv_nocmd = 1'b0;
      sbus.i_phv_valid = 1'b1;
      step();
      sbus.i_phv_valid = 1'b0;
      sbus.i_cmd_valid = 1'b1;
      sbus.i_cmd_offset = 7'd124;
      sbus.i_cmd_data = 8'h33;
      sbus.i_cmd_last = 1'b0;
      step();
      total++; if (sbus.o_oob !== 1'b0) begin bad++; $display("FAIL oob_early got=%b want=0", sbus.o_oob); end
      sbus.i_cmd_offset = 7'd126;
      sbus.i_cmd_data = 8'h77;
      sbus.i_cmd_last = 1'b1;
      step();
      sbus.i_cmd_valid = 1'b0;
      sbus.i_cmd_last = 1'b0;
      total++; if (sbus.o_phv_valid !== 1'b1) begin bad++; $display("FAIL oob_last_valid got=%b want=1", sbus.o_phv_valid); end
      total++; if (sbus.o_phv !== sexp) begin bad++; $display("FAIL oob_phv got=%h want=%h", sbus.o_phv[999:960], sexp[999:960]); end
      total++; if (sbus.o_oob !== 1'b1) begin bad++; $display("FAIL oob_flag got=%b want=1", sbus.o_oob); end
      total++; if (sbus.o_cmd_cnt !== 8'd2) begin bad++; $display("FAIL oob_cnt got=%0d want=2", sbus.o_cmd_cnt); end
      sbus.i_phv_ready = 1'b1;
      step();
      sbus.i_phv_ready = 1'b0;
      sbus.i_phv_nocmd = 1'b1;
      sbus.i_phv_valid = 1'b1;
      step();
      sbus.i_phv_valid = 1'b0;
      sbus.i_phv_nocmd = 1'b0;
      total++; if (sbus.o_oob !== 1'b0 || sbus.o_cmd_cnt !== 8'd0) begin
         bad++; $display("FAIL oob_clear oob=%b cnt=%0d want 0/0", sbus.o_oob, sbus.o_cmd_cnt);
      end
      sbus.i_phv_ready = 1'b1;
      step();
      sbus.i_phv_ready = 1'b0;
   endtask

   task automatic test_saturation();
      load_main('0, 1'b0);
      for (int k = 0; k < 300; k++) send_cmd(k % 128, 8'(k), (k == 299));
      total++; if (bus.o_cmd_cnt !== 8'(mcnt)) begin bad++; $display("FAIL sat_cnt got=%0d want=%0d", bus.o_cmd_cnt, mcnt); end
      total++; if (bus.o_phv !== model_phv()) begin bad++; $display("FAIL sat_phv got=%h want=%h", bus.o_phv[63:0], model_phv() >> 0); end
      accept_out();
   endtask

   task automatic test_random();
      logic [PW-1:0] v;
      logic nocmd;
      int ncmd;
      for (int p = 0; p < 20; p++) begin
         v = rand_phv();
         nocmd = ($urandom_range(0, 4) == 0);
         load_main(v, nocmd);
         if (!nocmd) begin
            ncmd = $urandom_range(1, 12);
            for (int k = 0; k < ncmd; k++) begin
               repeat ($urandom_range(0, 2)) step();
               send_cmd($urandom_range(0, 127), 8'($urandom()), (k == ncmd - 1));
            end
         end
         total++; if (bus.o_phv_valid !== 1'b1) begin bad++; $display("FAIL rnd_valid pkt=%0d got=%b want=1", p, bus.o_phv_valid); end
         total++; if (bus.o_phv !== model_phv()) begin bad++; $display("FAIL rnd_phv pkt=%0d got=%h want=%h", p, bus.o_phv[127:0], model_phv() >> 0); end
         total++; if (bus.o_cmd_cnt !== 8'(mcnt) || bus.o_oob !== 1'b0) begin
            bad++; $display("FAIL rnd_cnt pkt=%0d cnt=%0d oob=%b want %0d/0", p, bus.o_cmd_cnt, bus.o_oob, mcnt);
         end
         repeat ($urandom_range(0, 3)) step();
         accept_out();
      end
   endtask

   task automatic test_back_to_back();
      bus.i_phv_ready = 1'b1;
      load_main(rand_phv(), 1'b1);
      total++; if (bus.o_phv_valid !== 1'b1 || bus.o_phv_ready !== 1'b0) begin
         bad++; $display("FAIL b2b_out valid=%b ready=%b want 1/0", bus.o_phv_valid, bus.o_phv_ready);
      end
      total++; if (bus.o_phv !== model_phv()) begin bad++; $display("FAIL b2b_phv got=%h want=%h", bus.o_phv[63:0], model_phv() >> 0); end
      step();
      total++; if (bus.o_phv_valid !== 1'b0 || bus.o_phv_ready !== 1'b1) begin
         bad++; $display("FAIL b2b_idle valid=%b ready=%b want 0/1", bus.o_phv_valid, bus.o_phv_ready);
      end
      load_main(rand_phv(), 1'b1);
      total++; if (bus.o_phv !== model_phv()) begin bad++; $display("FAIL b2b_phv2 got=%h want=%h", bus.o_phv[63:0], model_phv() >> 0); end
      step();
      bus.i_phv_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      logic [PW-1:0] v;
      load_main(rand_phv(), 1'b0);
      send_cmd(1, 8'h12, 1'b0);
      send_cmd(2, 8'h34, 1'b0);
      total++; if (bus.o_cmd_cnt !== 8'd2) begin bad++; $display("FAIL ar_pre_cnt got=%0d want=2", bus.o_cmd_cnt); end
      #2 i_rst_n = 1'b0;
      #1;
      total++; if (bus.o_cmd_cnt !== 8'd0 || bus.o_phv !== '0) begin
         bad++; $display("FAIL ar_clear cnt=%0d phv=%h want 0/0", bus.o_cmd_cnt, bus.o_phv[63:0]);
      end
      total++; if (bus.o_cmd_ready !== 1'b0 || bus.o_phv_ready !== 1'b1 || bus.o_phv_valid !== 1'b0) begin
         bad++; $display("FAIL ar_state cmd_ready=%b phv_ready=%b valid=%b want 0/1/0",
                         bus.o_cmd_ready, bus.o_phv_ready, bus.o_phv_valid);
      end
      step();
      i_rst_n = 1'b1;
      step();
      load_main(rand_phv(), 1'b1);
      total++; if (bus.o_phv_valid !== 1'b1) begin bad++; $display("FAIL ar_out_pre got=%b want=1", bus.o_phv_valid); end
      #2 i_rst_n = 1'b0;
      #1;
      total++; if (bus.o_phv_valid !== 1'b0) begin bad++; $display("FAIL ar_out_drop got=%b want=0", bus.o_phv_valid); end
      step();
      i_rst_n = 1'b1;
      step();
      v = rand_phv();
      load_main(v, 1'b0);
      send_cmd(100, 8'h9C, 1'b1);
      total++; if (bus.o_phv !== model_phv() || bus.o_cmd_cnt !== 8'd1) begin
         bad++; $display("FAIL ar_after phv=%h cnt=%0d want %h/1", bus.o_phv[831:800], bus.o_cmd_cnt, v[831:800]);
      end
      accept_out();
   endtask

   initial begin
      bus.i_phv_valid = 1'b0;  bus.i_phv = '0;  bus.i_phv_nocmd = 1'b0;
      bus.i_cmd_valid = 1'b0;  bus.i_cmd_offset = '0;  bus.i_cmd_data = '0;
      bus.i_cmd_last = 1'b0;   bus.i_phv_ready = 1'b0;
      sbus.i_phv_valid = 1'b0; sbus.i_phv = '0; sbus.i_phv_nocmd = 1'b0;
      sbus.i_cmd_valid = 1'b0; sbus.i_cmd_offset = '0; sbus.i_cmd_data = '0;
      sbus.i_cmd_last = 1'b0;  sbus.i_phv_ready = 1'b0;
      mcnt = 0;
      repeat (3) step();
      test_reset();
      i_rst_n = 1'b1;
      step();
      test_single_write();
      test_overwrite();
      test_nocmd();
      test_backpressure();
      test_boundary();
      test_saturation();
      test_random();
      test_back_to_back();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
